// File: rtl/axis_straddle_unpacker.sv
// Straddled AXI4-Stream unpacker: buffers SEGS-segment beats in a small FIFO and
// emits one output beat per packet fragment, in arrival order, with protocol checking.
module axis_straddle_unpacker #(
  parameter int DATA_W = 512,
  parameter int SEGS   = 2,
  parameter int DEPTH  = 4
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [DATA_W-1:0]                   S_AXIS_TDATA,
  input  logic [DATA_W/32-1:0]                S_AXIS_TKEEP,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [SEGS-1:0]                     S_SOP,
  input  logic [SEGS*$clog2(SEGS)-1:0]        S_SOP_PTR,
  input  logic [SEGS-1:0]                     S_EOP,
  input  logic [SEGS*$clog2(DATA_W/32)-1:0]   S_EOP_PTR,
  input  logic                                S_DISCONTINUE,
  output logic [DATA_W-1:0]                   M_AXIS_TDATA,
  output logic [DATA_W/32-1:0]                M_AXIS_TKEEP,
  output logic                                M_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TUSER,
  output logic [$clog2(DEPTH):0]              fifo_level,
  output logic [31:0]                         pkt_count,
  output logic                                error_protocol
);

  localparam int KEEP_W = DATA_W / 32;
  localparam int SEG_W  = DATA_W / SEGS;
  localparam int DPS    = KEEP_W / SEGS;
  localparam int SPW    = $clog2(SEGS);
  localparam int EPW    = $clog2(KEEP_W);
  localparam int DPW    = $clog2(DPS);
  localparam int LW     = $clog2(DEPTH);
  localparam int CW     = $clog2(SEGS + 1);

  // Beat FIFO storage
  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [KEEP_W-1:0]   keep_mem [DEPTH];
  logic [SEGS-1:0]     sop_mem  [DEPTH];
  logic [SEGS*SPW-1:0] sptr_mem [DEPTH];
  logic [SEGS-1:0]     eop_mem  [DEPTH];
  logic [SEGS*EPW-1:0] eptr_mem [DEPTH];
  logic                disc_mem [DEPTH];

  logic [LW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [LW:0]   level_reg, level_next;
  logic          open_reg, open_next;
  logic [CW-1:0] frag_idx_reg, frag_idx_next;
  logic [31:0]   pkt_count_reg, pkt_count_next;
  logic          err_reg, err_next;

  logic [DATA_W-1:0]   h_data;
  logic [KEEP_W-1:0]   h_keep;
  logic [SEGS-1:0]     h_sop, h_eop;
  logic [SEGS*SPW-1:0] h_sptr;
  logic [SEGS*EPW-1:0] h_eptr;
  logic                h_disc;

  logic [CW-1:0]  n_sop, n_eop, nf;
  logic [SPW-1:0] frag_start [SEGS];
  logic [SPW-1:0] frag_end   [SEGS];
  logic [SPW-1:0] frag_eseg  [SEGS];
  logic           bad;

  logic [SPW-1:0] cur, cur_start, cur_end;
  logic [EPW-1:0] cur_eptr;
  logic           cur_ends, last_frag;
  logic [SEGS-1:0] seg_on;

  logic s_ready, push, accept, discard, pop;

  assign h_data = data_mem[rd_ptr_reg];
  assign h_keep = keep_mem[rd_ptr_reg];
  assign h_sop  = sop_mem[rd_ptr_reg];
  assign h_sptr = sptr_mem[rd_ptr_reg];
  assign h_eop  = eop_mem[rd_ptr_reg];
  assign h_eptr = eptr_mem[rd_ptr_reg];
  assign h_disc = disc_mem[rd_ptr_reg];

  // Whole-beat decode: fragment boundaries and malformation check
  always_comb begin
    n_sop = '0;
    n_eop = '0;
    for (int i = 0; i < SEGS; i++) begin
      n_sop = n_sop + CW'(h_sop[i]);
      n_eop = n_eop + CW'(h_eop[i]);
    end
    nf = CW'(open_reg) + n_sop;
    for (int k = 0; k < SEGS; k++) begin
      if (open_reg && k == 0)
        frag_start[k] = '0;
      else if (open_reg)
        frag_start[k] = h_sptr[((k == 0) ? 0 : k - 1)*SPW +: SPW];
      else
        frag_start[k] = h_sptr[k*SPW +: SPW];
      frag_eseg[k] = h_eptr[k*EPW + DPW +: SPW];
      frag_end[k]  = h_eop[k] ? frag_eseg[k] : SPW'(SEGS - 1);
    end
    bad = (nf == '0) || (n_eop > nf) || (nf > CW'(SEGS)) ||
          ((h_sop & (h_sop + SEGS'(1))) != '0) ||
          ((h_eop & (h_eop + SEGS'(1))) != '0);
    for (int i = 1; i < SEGS; i++) begin
      if ((CW'(i) < n_sop) && (h_sptr[i*SPW +: SPW] <= h_sptr[(i-1)*SPW +: SPW]))
        bad = 1'b1;
    end
    for (int k = 0; k < SEGS; k++) begin
      if (CW'(k) < nf) begin
        if (k > 0 && frag_start[k] <= frag_end[(k == 0) ? 0 : k - 1])
          bad = 1'b1;
        if (h_eop[k] && frag_eseg[k] < frag_start[k])
          bad = 1'b1;
      end
    end
  end

  assign cur       = frag_idx_reg[SPW-1:0];
  assign cur_start = frag_start[cur];
  assign cur_end   = frag_end[cur];
  assign cur_ends  = h_eop[cur];
  assign cur_eptr  = h_eptr[cur*EPW +: EPW];
  assign last_frag = (frag_idx_reg == nf - CW'(1));

  genvar gi;
  generate
    for (gi = 0; gi < SEGS; gi++) begin : g_seg
      assign seg_on[gi] = (SPW'(gi) >= cur_start) && (SPW'(gi) <= cur_end);
      assign M_AXIS_TDATA[gi*SEG_W +: SEG_W] = seg_on[gi] ? h_data[gi*SEG_W +: SEG_W] : '0;
    end
    for (gi = 0; gi < KEEP_W; gi++) begin : g_keep
      assign M_AXIS_TKEEP[gi] = h_keep[gi] && seg_on[gi/DPS] && (!cur_ends || (EPW'(gi) <= cur_eptr));
    end
  endgenerate

  assign M_AXIS_TVALID  = (level_reg != '0) && !bad;
  assign M_AXIS_TLAST   = cur_ends;
  assign M_AXIS_TUSER   = h_disc && cur_ends && (frag_idx_reg == n_eop - CW'(1));
  assign s_ready        = (level_reg != (LW+1)'(DEPTH));
  assign S_AXIS_TREADY  = s_ready;
  assign fifo_level     = level_reg;
  assign pkt_count      = pkt_count_reg;
  assign error_protocol = err_reg;

  always_comb begin
    push    = S_AXIS_TVALID && s_ready;
    accept  = M_AXIS_TVALID && M_AXIS_TREADY;
    discard = (level_reg != '0) && bad;
    pop     = discard || (accept && last_frag);

    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    open_next      = open_reg;
    frag_idx_next  = frag_idx_reg;
    pkt_count_next = pkt_count_reg;
    err_next       = discard;

    if (push)
      wr_ptr_next = wr_ptr_reg + LW'(1);
    if (pop)
      rd_ptr_next = rd_ptr_reg + LW'(1);
    case ({push, pop})
      2'b10:   level_next = level_reg + (LW+1)'(1);
      2'b01:   level_next = level_reg - (LW+1)'(1);
      default: level_next = level_reg;
    endcase

    if (discard) begin
      open_next     = 1'b0;
      frag_idx_next = '0;
    end else if (accept) begin
      if (last_frag) begin
        frag_idx_next = '0;
        open_next     = !cur_ends;
      end else begin
        frag_idx_next = frag_idx_reg + CW'(1);
      end
      if (cur_ends)
        pkt_count_next = pkt_count_reg + 32'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= S_AXIS_TDATA;
      keep_mem[wr_ptr_reg] <= S_AXIS_TKEEP;
      sop_mem[wr_ptr_reg]  <= S_SOP;
      sptr_mem[wr_ptr_reg] <= S_SOP_PTR;
      eop_mem[wr_ptr_reg]  <= S_EOP;
      eptr_mem[wr_ptr_reg] <= S_EOP_PTR;
      disc_mem[wr_ptr_reg] <= S_DISCONTINUE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      open_reg      <= 1'b0;
      frag_idx_reg  <= '0;
      pkt_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      open_reg      <= open_next;
      frag_idx_reg  <= frag_idx_next;
      pkt_count_reg <= pkt_count_next;
      err_reg       <= err_next;
    end
  end

endmodule
